// File: rtl/lora_tx_scheduler.sv
// Packet-level sequencer for the LoRa transmit chain (4 MHz divided-clock domain).
// Gates the oscillator and holds the packet generator in reset except while a
// packet is on air. It also latches SF/BW per packet and counts symDone pulses.
// Warm-up, inter-packet gap, packet quota and a per-symbol watchdog are enforced here.
module lora_tx_scheduler #(
    parameter int WARMUP_CYCLES = 4000,
    parameter int SYM_TIMEOUT   = 1048576,
    parameter int CNT_W         = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_lock,
    input  logic             enable,
    input  logic             sym_done,
    input  logic [11:0]      pkt_syms,
    input  logic [2:0]       sf_cfg,
    input  logic [2:0]       bw_cfg,
    input  logic [CNT_W-1:0] gap_cycles,
    input  logic [15:0]      max_pkts,
    output logic             osc_en,
    output logic             gen_rst,
    output logic [2:0]       sf_select,
    output logic [2:0]       bw_select,
    output logic             busy,
    output logic [15:0]      pkt_count,
    output logic             err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_START  = 3'd2,
        ST_TX     = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Counters count down to zero, so a duration of N cycles loads N-1.
    localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDOG_LOAD = CNT_W'(SYM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  warm_cnt_r, warm_cnt_nxt_s;
    logic [CNT_W-1:0]  gap_cnt_r, gap_cnt_nxt_s;
    logic [CNT_W-1:0]  wdog_r, wdog_nxt_s;
    logic [11:0]       sym_cnt_r, sym_cnt_nxt_s;
    logic [2:0]        sf_select_r, sf_select_nxt_s;
    logic [2:0]        bw_select_r, bw_select_nxt_s;
    logic [15:0]       pkt_count_r, pkt_count_nxt_s;
    logic              err_r, err_nxt_s;
    logic              osc_en_r, osc_en_nxt_s;
    logic              gen_rst_r, gen_rst_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic [11:0]       last_sym_s;
    logic [CNT_W-1:0]  gap_load_s;
    logic              quota_ok_s;

    // Helpers: final symbol index (zero-length packet acts as one symbol), gap
    // reload (a zero gap still spends one cycle in GAP), and quota test.
    always_comb begin
        last_sym_s = (pkt_syms == 12'd0) ? 12'd0 : (pkt_syms - 12'd1);
        gap_load_s = (gap_cycles == CNT_ZERO) ? CNT_ZERO : (gap_cycles - CNT_ONE);
        quota_ok_s = (max_pkts == 16'd0) || (pkt_count_r < max_pkts);
    end

    // Next-state and next-register logic; lock loss overrides everything.
    always_comb begin
        state_nxt_s     = state_r;
        warm_cnt_nxt_s  = warm_cnt_r;
        gap_cnt_nxt_s   = gap_cnt_r;
        wdog_nxt_s      = wdog_r;
        sym_cnt_nxt_s   = sym_cnt_r;
        sf_select_nxt_s = sf_select_r;
        bw_select_nxt_s = bw_select_r;
        pkt_count_nxt_s = pkt_count_r;
        err_nxt_s       = err_r;

        if (!clk_lock) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        state_nxt_s     = ST_WARMUP;
                        pkt_count_nxt_s = 16'd0;
                        err_nxt_s       = 1'b0;
                        warm_cnt_nxt_s  = WARM_LOAD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WARMUP: begin
                    if (!enable) begin
                        state_nxt_s = ST_IDLE;
                    end else if (warm_cnt_r == CNT_ZERO) begin
                        state_nxt_s = ST_START;
                    end else begin
                        warm_cnt_nxt_s = warm_cnt_r - CNT_ONE;
                    end
                end
                ST_START: begin
                    sf_select_nxt_s = sf_cfg;
                    bw_select_nxt_s = bw_cfg;
                    sym_cnt_nxt_s   = 12'd0;
                    wdog_nxt_s      = WDOG_LOAD;
                    state_nxt_s     = ST_TX;
                end
                ST_TX: begin
                    // A symbol arriving on the expiry cycle still counts.
                    if (sym_done) begin
                        if (sym_cnt_r == last_sym_s) begin
                            state_nxt_s     = ST_GAP;
                            gap_cnt_nxt_s   = gap_load_s;
                            pkt_count_nxt_s = (pkt_count_r == 16'hFFFF) ? pkt_count_r
                                                                       : (pkt_count_r + 16'd1);
                        end else begin
                            sym_cnt_nxt_s = sym_cnt_r + 12'd1;
                            wdog_nxt_s    = WDOG_LOAD;
                        end
                    end else if (wdog_r == CNT_ZERO) begin
                        err_nxt_s     = 1'b1;
                        state_nxt_s   = ST_GAP;
                        gap_cnt_nxt_s = gap_load_s;
                    end else begin
                        wdog_nxt_s = wdog_r - CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == CNT_ZERO) begin
                        if (enable && quota_ok_s) begin
                            state_nxt_s = ST_START;
                        end else if (!enable) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_DONE;
                        end
                    end else begin
                        gap_cnt_nxt_s = gap_cnt_r - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs track it.
    // The generator leaves reset only once TX is already established, and is
    // put back in reset on the same edge that leaves TX.
    always_comb begin
        busy_nxt_s    = (state_nxt_s == ST_WARMUP) || (state_nxt_s == ST_START) ||
                        (state_nxt_s == ST_TX)     || (state_nxt_s == ST_GAP);
        osc_en_nxt_s  = busy_nxt_s;
        gen_rst_nxt_s = !((state_r == ST_TX) && (state_nxt_s == ST_TX));
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            warm_cnt_r  <= CNT_ZERO;
            gap_cnt_r   <= CNT_ZERO;
            wdog_r      <= CNT_ZERO;
            sym_cnt_r   <= 12'd0;
            sf_select_r <= 3'd0;
            bw_select_r <= 3'd0;
            pkt_count_r <= 16'd0;
            err_r       <= 1'b0;
            osc_en_r    <= 1'b0;
            gen_rst_r   <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            warm_cnt_r  <= warm_cnt_nxt_s;
            gap_cnt_r   <= gap_cnt_nxt_s;
            wdog_r      <= wdog_nxt_s;
            sym_cnt_r   <= sym_cnt_nxt_s;
            sf_select_r <= sf_select_nxt_s;
            bw_select_r <= bw_select_nxt_s;
            pkt_count_r <= pkt_count_nxt_s;
            err_r       <= err_nxt_s;
            osc_en_r    <= osc_en_nxt_s;
            gen_rst_r   <= gen_rst_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign osc_en    = osc_en_r;
    assign gen_rst   = gen_rst_r;
    assign sf_select = sf_select_r;
    assign bw_select = bw_select_r;
    assign busy      = busy_r;
    assign pkt_count = pkt_count_r;
    assign err       = err_r;

endmodule

// File: tb/tb_lora_tx_scheduler.sv
// Self-checking bench for lora_tx_scheduler. Expected SF/BW per packet are
// queued when the configuration is driven and popped when TX starts.
module tb_lora_tx_scheduler;

    localparam int WARM = 4;
    localparam int TMO  = 50;
    localparam int CW   = 24;

    logic          clk = 1'b0;
    logic          rst_n, clk_lock, enable, sym_done;
    logic [11:0]   pkt_syms;
    logic [2:0]    sf_cfg, bw_cfg;
    logic [CW-1:0] gap_cycles;
    logic [15:0]   max_pkts;
    logic          osc_en, gen_rst, busy, err;
    logic [2:0]    sf_select, bw_select;
    logic [15:0]   pkt_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [5:0] exp_q[$];

    lora_tx_scheduler #(.WARMUP_CYCLES(WARM), .SYM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clk_lock(clk_lock), .enable(enable),
        .sym_done(sym_done), .pkt_syms(pkt_syms), .sf_cfg(sf_cfg), .bw_cfg(bw_cfg),
        .gap_cycles(gap_cycles), .max_pkts(max_pkts), .osc_en(osc_en),
        .gen_rst(gen_rst), .sf_select(sf_select), .bw_select(bw_select),
        .busy(busy), .pkt_count(pkt_count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until gen_rst reaches level; cycles = -1 when the bound expires.
    task automatic wait_gen_rst(input logic level, input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (gen_rst === level) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic sym_pulse(input int idle_before);
        repeat (idle_before) step();
        sym_done = 1'b1;
        step();
        sym_done = 1'b0;
    endtask

    function automatic logic [5:0] sb_pop();
        if (exp_q.size() == 0) return 6'bxxxxxx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; clk_lock = 1'b1; enable = 1'b0; sym_done = 1'b0;
        pkt_syms = 12'd10; sf_cfg = 3'd7; bw_cfg = 3'd2;
        gap_cycles = 24'd8; max_pkts = 16'd3;
        repeat (3) step();
        n_checks++; if (osc_en !== 1'b0) $display("FAIL rst_osc_en: got %b want 0", osc_en); else n_pass++;
        n_checks++; if (gen_rst !== 1'b1) $display("FAIL rst_gen_rst: got %b want 1", gen_rst); else n_pass++;
        n_checks++; if ({sf_select, bw_select} !== 6'd0) $display("FAIL rst_sf_bw: got %0d/%0d want 0/0", sf_select, bw_select); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (pkt_count !== 16'd0) $display("FAIL rst_pkt_count: got %0d want 0", pkt_count); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
        rst_n = 1'b1;
        step();
        n_checks++; if (osc_en !== 1'b0) $display("FAIL idle_osc_en: got %b want 0", osc_en); else n_pass++;
    endtask

    // Warm-up timing, three-packet quota, SF/BW latching, gaps, DONE.
    task automatic test_packets();
        int cyc;
        logic [5:0] exp;
        exp_q.push_back({3'd7, 3'd2});
        exp_q.push_back({3'd5, 3'd0});
        exp_q.push_back({3'd5, 3'd0});
        enable = 1'b1;
        step();
        n_checks++; if (osc_en !== 1'b1) $display("FAIL warmup_osc_rise: got %b want 1", osc_en); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL warmup_busy: got %b want 1", busy); else n_pass++;
        wait_gen_rst(1'b0, 20, cyc);
        n_checks++; if (cyc != WARM + 2) $display("FAIL warmup_to_tx: got %0d cycles want %0d", cyc, WARM + 2); else n_pass++;
        for (int p = 0; p < 3; p++) begin
            exp = sb_pop();
            n_checks++; if ({sf_select, bw_select} !== exp) $display("FAIL pkt_cfg: got %0d/%0d want %0d/%0d", sf_select, bw_select, exp[5:3], exp[2:0]); else n_pass++;
            for (int s = 1; s <= 10; s++) begin
                sym_pulse(19);
                // Select codes are 3 bits wide; 5/0 stands in for the "changed" configuration.
                if (s == 3 && p == 0) begin sf_cfg = 3'd5; bw_cfg = 3'd0; end
                if (s == 9) begin
                    n_checks++; if (gen_rst !== 1'b0) $display("FAIL pkt_mid_gen_rst: got %b want 0", gen_rst); else n_pass++;
                end
            end
            n_checks++; if (gen_rst !== 1'b1) $display("FAIL pkt_end_gen_rst: got %b want 1", gen_rst); else n_pass++;
            n_checks++; if (pkt_count !== 16'(p + 1)) $display("FAIL pkt_count: got %0d want %0d", pkt_count, p + 1); else n_pass++;
            n_checks++; if ({sf_select, bw_select} !== exp) $display("FAIL cfg_held: got %0d/%0d want %0d/%0d", sf_select, bw_select, exp[5:3], exp[2:0]); else n_pass++;
            if (p < 2) begin
                wait_gen_rst(1'b0, 30, cyc);
                n_checks++; if (cyc != 10) $display("FAIL gap_len: got %0d cycles want 10", cyc); else n_pass++;
            end
        end
        repeat (7) step();
        n_checks++; if (osc_en !== 1'b1) $display("FAIL last_gap_osc: got %b want 1", osc_en); else n_pass++;
        step();
        n_checks++; if ({osc_en, busy} !== 2'b00) $display("FAIL done_osc_busy: got %b%b want 00", osc_en, busy); else n_pass++;
        n_checks++; if (pkt_count !== 16'd3) $display("FAIL done_pkt_count: got %0d want 3", pkt_count); else n_pass++;
        enable = 1'b0;
        step();
        n_checks++; if (pkt_count !== 16'd3) $display("FAIL idle_pkt_hold: got %0d want 3", pkt_count); else n_pass++;
    endtask

    // Coincident symbol keeps the packet alive; a stall trips the watchdog.
    task automatic test_watchdog();
        int cyc;
        logic [5:0] exp;
        max_pkts = 16'd0; sf_cfg = 3'd3; bw_cfg = 3'd1;
        exp_q.push_back({3'd3, 3'd1});
        exp_q.push_back({3'd3, 3'd1});
        enable = 1'b1;
        step();
        wait_gen_rst(1'b0, 20, cyc);
        n_checks++; if (cyc != WARM + 2) $display("FAIL wd_tx_start: got %0d cycles want %0d", cyc, WARM + 2); else n_pass++;
        exp = sb_pop();
        n_checks++; if ({sf_select, bw_select} !== exp) $display("FAIL wd_cfg1: got %0d/%0d want %0d/%0d", sf_select, bw_select, exp[5:3], exp[2:0]); else n_pass++;
        sym_pulse(TMO - 2);
        n_checks++; if ({gen_rst, err} !== 2'b00) $display("FAIL wd_coincident: got gen_rst=%b err=%b want 0 0", gen_rst, err); else n_pass++;
        wait_gen_rst(1'b1, 100, cyc);
        n_checks++; if (cyc != TMO) $display("FAIL wd_expiry_cycles: got %0d want %0d", cyc, TMO); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL wd_err: got %b want 1", err); else n_pass++;
        n_checks++; if (pkt_count !== 16'd0) $display("FAIL wd_pkt_count: got %0d want 0", pkt_count); else n_pass++;
        wait_gen_rst(1'b0, 30, cyc);
        n_checks++; if (cyc != 10) $display("FAIL wd_restart: got %0d cycles want 10", cyc); else n_pass++;
        exp = sb_pop();
        n_checks++; if ({sf_select, bw_select} !== exp) $display("FAIL wd_cfg2: got %0d/%0d want %0d/%0d", sf_select, bw_select, exp[5:3], exp[2:0]); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL wd_err_sticky: got %b want 1", err); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({osc_en, gen_rst, busy, err} !== 4'b0100) $display("FAIL async_rst: got osc=%b gen_rst=%b busy=%b err=%b want 0 1 0 0", osc_en, gen_rst, busy, err); else n_pass++;
        step();
        rst_n = 1'b1; enable = 1'b0;
        step();
    endtask

    // Enable dropped mid-packet: packet and gap complete, then IDLE.
    task automatic test_graceful_stop();
        int cyc;
        logic [5:0] exp;
        sf_cfg = 3'd1; bw_cfg = 3'd4;
        exp_q.push_back({3'd1, 3'd4});
        enable = 1'b1;
        step();
        wait_gen_rst(1'b0, 20, cyc);
        n_checks++; if (cyc != WARM + 2) $display("FAIL stop_tx_start: got %0d cycles want %0d", cyc, WARM + 2); else n_pass++;
        exp = sb_pop();
        n_checks++; if ({sf_select, bw_select} !== exp) $display("FAIL stop_cfg: got %0d/%0d want %0d/%0d", sf_select, bw_select, exp[5:3], exp[2:0]); else n_pass++;
        for (int s = 1; s <= 10; s++) begin
            sym_pulse(4);
            if (s == 3) enable = 1'b0;
            if (s == 9) begin
                n_checks++; if (gen_rst !== 1'b0) $display("FAIL stop_mid_tx: got %b want 0", gen_rst); else n_pass++;
            end
        end
        n_checks++; if ({gen_rst, pkt_count} !== {1'b1, 16'd1}) $display("FAIL stop_pkt_end: got gen_rst=%b cnt=%0d want 1 1", gen_rst, pkt_count); else n_pass++;
        repeat (7) step();
        n_checks++; if (osc_en !== 1'b1) $display("FAIL stop_gap_osc: got %b want 1", osc_en); else n_pass++;
        step();
        n_checks++; if ({osc_en, busy} !== 2'b00) $display("FAIL stop_idle: got %b%b want 00", osc_en, busy); else n_pass++;
        repeat (5) step();
        n_checks++; if ({busy, pkt_count} !== {1'b0, 16'd1}) $display("FAIL stop_stays_idle: got busy=%b cnt=%0d want 0 1", busy, pkt_count); else n_pass++;
    endtask

    // Lock loss mid-TX, ignored symbols, relock clears the packet count.
    task automatic test_lock_loss();
        int cyc;
        logic [5:0] exp;
        pkt_syms = 12'd2; sf_cfg = 3'd2; bw_cfg = 3'd3;
        repeat (3) exp_q.push_back({3'd2, 3'd3});
        enable = 1'b1;
        step();
        wait_gen_rst(1'b0, 20, cyc);
        exp = sb_pop();
        n_checks++; if ({sf_select, bw_select} !== exp) $display("FAIL lock_cfg1: got %0d/%0d want %0d/%0d", sf_select, bw_select, exp[5:3], exp[2:0]); else n_pass++;
        sym_pulse(2);
        sym_pulse(2);
        n_checks++; if (pkt_count !== 16'd1) $display("FAIL lock_pkt1: got %0d want 1", pkt_count); else n_pass++;
        wait_gen_rst(1'b0, 30, cyc);
        exp = sb_pop();
        n_checks++; if ({sf_select, bw_select} !== exp) $display("FAIL lock_cfg2: got %0d/%0d want %0d/%0d", sf_select, bw_select, exp[5:3], exp[2:0]); else n_pass++;
        sym_pulse(2);
        clk_lock = 1'b0;
        step();
        n_checks++; if ({osc_en, gen_rst, busy} !== 3'b010) $display("FAIL lock_drop: got osc=%b gen_rst=%b busy=%b want 0 1 0", osc_en, gen_rst, busy); else n_pass++;
        n_checks++; if (pkt_count !== 16'd1) $display("FAIL lock_cnt_hold: got %0d want 1", pkt_count); else n_pass++;
        sym_pulse(2);
        sym_pulse(2);
        n_checks++; if ({osc_en, gen_rst, pkt_count} !== {1'b0, 1'b1, 16'd1}) $display("FAIL lock_sym_ignored: got osc=%b gen_rst=%b cnt=%0d want 0 1 1", osc_en, gen_rst, pkt_count); else n_pass++;
        clk_lock = 1'b1;
        step();
        n_checks++; if ({osc_en, pkt_count} !== {1'b1, 16'd0}) $display("FAIL relock: got osc=%b cnt=%0d want 1 0", osc_en, pkt_count); else n_pass++;
        wait_gen_rst(1'b0, 20, cyc);
        n_checks++; if (cyc != WARM + 2) $display("FAIL relock_tx: got %0d cycles want %0d", cyc, WARM + 2); else n_pass++;
        exp = sb_pop();
        n_checks++; if ({sf_select, bw_select} !== exp) $display("FAIL lock_cfg3: got %0d/%0d want %0d/%0d", sf_select, bw_select, exp[5:3], exp[2:0]); else n_pass++;
        clk_lock = 1'b0; enable = 1'b0;
        step();
        clk_lock = 1'b1;
        step();
    endtask

    // Warm-up abort, zero-length packet, zero gap and small quota.
    task automatic test_boundaries();
        int cyc;
        logic [5:0] exp;
        enable = 1'b1;
        step();
        enable = 1'b0;
        step();
        n_checks++; if ({osc_en, busy} !== 2'b00) $display("FAIL warmup_abort: got %b%b want 00", osc_en, busy); else n_pass++;
        pkt_syms = 12'd0; gap_cycles = 24'd0; max_pkts = 16'd2; sf_cfg = 3'd6; bw_cfg = 3'd5;
        exp_q.push_back({3'd6, 3'd5});
        exp_q.push_back({3'd6, 3'd5});
        enable = 1'b1;
        step();
        wait_gen_rst(1'b0, 20, cyc);
        exp = sb_pop();
        n_checks++; if ({sf_select, bw_select} !== exp) $display("FAIL zero_cfg1: got %0d/%0d want %0d/%0d", sf_select, bw_select, exp[5:3], exp[2:0]); else n_pass++;
        sym_pulse(1);
        n_checks++; if ({gen_rst, pkt_count} !== {1'b1, 16'd1}) $display("FAIL zero_syms_end: got gen_rst=%b cnt=%0d want 1 1", gen_rst, pkt_count); else n_pass++;
        wait_gen_rst(1'b0, 10, cyc);
        n_checks++; if (cyc != 3) $display("FAIL zero_gap_len: got %0d cycles want 3", cyc); else n_pass++;
        exp = sb_pop();
        n_checks++; if ({sf_select, bw_select} !== exp) $display("FAIL zero_cfg2: got %0d/%0d want %0d/%0d", sf_select, bw_select, exp[5:3], exp[2:0]); else n_pass++;
        sym_pulse(1);
        n_checks++; if (pkt_count !== 16'd2) $display("FAIL quota_cnt: got %0d want 2", pkt_count); else n_pass++;
        step();
        n_checks++; if ({osc_en, busy} !== 2'b00) $display("FAIL quota_done: got %b%b want 00", osc_en, busy); else n_pass++;
        step();
        n_checks++; if ({osc_en, gen_rst, pkt_count} !== {1'b0, 1'b1, 16'd2}) $display("FAIL done_hold: got osc=%b gen_rst=%b cnt=%0d want 0 1 2", osc_en, gen_rst, pkt_count); else n_pass++;
        enable = 1'b0;
        step();
        n_checks++; if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_packets();
        test_watchdog();
        test_graceful_stop();
        test_lock_loss();
        test_boundaries();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete within 50000 cycles");
        $fatal(1);
    end

endmodule
